// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants, address type and width helper for the register file
package rf_pkg;

  localparam int RF_W    = 32;
  localparam int RF_N    = 32;
  localparam int RF_RD_N = 2;
  localparam int RF_WR_N = 1;
  localparam int RF_AW   = $clog2(RF_N);

  typedef logic [RF_AW-1:0] rf_addr_t;

  // Select/index width that stays at least one bit when only one choice exists.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dec.sv
// rtl/dec.sv - enabled binary-to-one-hot address decoder
module dec #(
  parameter int N  = 4,
  parameter int AW = 2
) (
  input  logic          en,
  input  logic [AW-1:0] a,
  output logic [N-1:0]  y
);

  // One-hot decode of the address, all zero when disabled.
  always_comb begin
    y = '0;
    for (int i = 0; i < N; i++) begin
      if (en && (a == AW'(i))) y[i] = 1'b1;
    end
  end

endmodule

// File: rtl/dffen.sv
// rtl/dffen.sv - enabled D flip-flop bank with asynchronous active-low reset
module dffen #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load on enable, clear immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/icg.sv
// rtl/icg.sv - latch-based integrated clock gate
module icg (
  input  logic clk,
  input  logic en,
  output logic gclk
);

  logic en_l;

  // Enable is captured while the clock is low so the gated clock never glitches.
  always_latch begin
    if (!clk) en_l <= en;
  end

  assign gclk = clk & en_l;

endmodule

// File: rtl/mux.sv
// rtl/mux.sv - N-to-1 word multiplexer over a flattened input bus
module mux #(
  parameter int N  = 2,
  parameter int W  = 1,
  parameter int SW = 1
) (
  input  logic [N*W-1:0] d,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   y
);

  // Compare-based select keeps single-input instances free of index-width quirks.
  always_comb begin
    y = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) y = d[i*W +: W];
    end
  end

endmodule

// File: rtl/rf_wr_arb.sv
// rtl/rf_wr_arb.sv - per-word write-port priority select, highest port wins
module rf_wr_arb import rf_pkg::*; #(
  parameter int WR_N = 1,
  parameter int PW   = idx_w(WR_N)
) (
  input  logic [WR_N-1:0] req,
  output logic            en,
  output logic [PW-1:0]   idx
);

  // Ascending scan so the last (highest-numbered) requesting port ends up selected.
  always_comb begin
    en  = |req;
    idx = '0;
    for (int p = 0; p < WR_N; p++) begin
      if (req[p]) idx = PW'(p);
    end
  end

endmodule

// File: rtl/rf_byp.sv
// rtl/rf_byp.sv - multi-port register file with word-valid tracking and optional write bypass
module rf_byp import rf_pkg::*; #(
  parameter int W      = RF_W,
  parameter int N      = RF_N,
  parameter int RD_N   = RF_RD_N,
  parameter int WR_N   = RF_WR_N,
  parameter int BYP_EN = 1
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      i_clr,
  input  logic [WR_N-1:0]           i_wr_en,
  input  logic [WR_N*$clog2(N)-1:0] i_wr_wa,
  input  logic [WR_N*W-1:0]         i_wr_data,
  input  logic [RD_N-1:0]           i_rd_en,
  input  logic [RD_N*$clog2(N)-1:0] i_rd_ra,
  output logic [RD_N-1:0]           o_rd_vld,
  output logic [RD_N*W-1:0]         o_rd_data,
  output logic [RD_N-1:0]           o_rd_init
);

  localparam int AW = $clog2(N);
  localparam int PW = idx_w(WR_N);

  logic [WR_N*N-1:0] hit;       // port p targets word w at bit p*N+w
  logic [N-1:0]      wen_all;   // word is written this cycle
  logic [N-1:0]      vld;       // word-valid bits
  logic [N-1:0]      vld_nxt;
  logic [N-1:0]      view_v;    // valid as seen by readers
  logic [N*W-1:0]    view_d;    // masked data as seen by readers

  // Address decode per write port.
  for (genvar p = 0; p < WR_N; p++) begin : g_wdec
    dec #(.N(N), .AW(AW)) u_dec (
      .en (i_wr_en[p]),
      .a  (i_wr_wa[p*AW +: AW]),
      .y  (hit[p*N +: N])
    );
  end

  // A write sets the bit even when clear is asserted in the same cycle.
  assign vld_nxt = wen_all | (vld & ~{N{i_clr}});

  dffen #(.W(N)) u_vld (
    .clk   (clk),
    .rst_n (arst_n),
    .en    (1'b1),
    .d     (vld_nxt),
    .q     (vld)
  );

  for (genvar w = 0; w < N; w++) begin : g_word
    logic [WR_N-1:0] req;
    logic            wen;
    logic [PW-1:0]   widx;
    logic [W-1:0]    wd;
    logic            gclk;
    logic [W-1:0]    mem_q;
    logic            v_vld;
    logic [W-1:0]    v_d;

    for (genvar p = 0; p < WR_N; p++) begin : g_req
      assign req[p] = hit[p*N + w];
    end

    rf_wr_arb #(.WR_N(WR_N), .PW(PW)) u_arb (
      .req (req),
      .en  (wen),
      .idx (widx)
    );

    mux #(.N(WR_N), .W(W), .SW(PW)) u_wmux (
      .d   (i_wr_data),
      .sel (widx),
      .y   (wd)
    );

    icg u_icg (
      .clk  (clk),
      .en   (wen),
      .gclk (gclk)
    );

    // Storage is clocked only on a write and never reset; the valid bit masks stale data.
    always_ff @(posedge gclk) begin
      mem_q <= wd;
    end

    assign wen_all[w] = wen;

    if (BYP_EN != 0) begin : g_byp
      assign v_vld = vld_nxt[w];
      assign v_d   = wen ? wd : mem_q;
    end else begin : g_nobyp
      assign v_vld = vld[w];
      assign v_d   = mem_q;
    end

    assign view_v[w]          = v_vld;
    assign view_d[w*W +: W]   = v_vld ? v_d : '0;
  end

  for (genvar r = 0; r < RD_N; r++) begin : g_rd
    logic [W-1:0] rdat;
    logic         rini;

    mux #(.N(N), .W(W), .SW(AW)) u_dmux (
      .d   (view_d),
      .sel (i_rd_ra[r*AW +: AW]),
      .y   (rdat)
    );

    mux #(.N(N), .W(1), .SW(AW)) u_vmux (
      .d   (view_v),
      .sel (i_rd_ra[r*AW +: AW]),
      .y   (rini)
    );

    dffen #(.W(1)) u_rvld (
      .clk   (clk),
      .rst_n (arst_n),
      .en    (1'b1),
      .d     (i_rd_en[r]),
      .q     (o_rd_vld[r])
    );

    dffen #(.W(W)) u_rdat (
      .clk   (clk),
      .rst_n (arst_n),
      .en    (i_rd_en[r]),
      .d     (rdat),
      .q     (o_rd_data[r*W +: W])
    );

    dffen #(.W(1)) u_rini (
      .clk   (clk),
      .rst_n (arst_n),
      .en    (i_rd_en[r]),
      .d     (rini),
      .q     (o_rd_init[r])
    );
  end

endmodule

// File: tb/tb_rf_byp.sv
// tb/tb_rf_byp.sv - directed bench for rf_byp with bypass and non-bypass instances side by side
module tb_rf_byp;

  localparam int W    = 32;
  localparam int N    = 32;
  localparam int RD_N = 2;
  localparam int WR_N = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                arst_n = 1'b0;
  logic                i_clr;
  logic [WR_N-1:0]     i_wr_en;
  logic [WR_N*AW-1:0]  i_wr_wa;
  logic [WR_N*W-1:0]   i_wr_data;
  logic [RD_N-1:0]     i_rd_en;
  logic [RD_N*AW-1:0]  i_rd_ra;

  logic [RD_N-1:0]     vld_b, init_b, vld_n, init_n;
  logic [RD_N*W-1:0]   data_b, data_n;

  int n_checks = 0;
  int n_fail   = 0;

  rf_byp #(.W(W), .N(N), .RD_N(RD_N), .WR_N(WR_N), .BYP_EN(1)) u_dut_b (
    .clk       (clk),
    .arst_n    (arst_n),
    .i_clr     (i_clr),
    .i_wr_en   (i_wr_en),
    .i_wr_wa   (i_wr_wa),
    .i_wr_data (i_wr_data),
    .i_rd_en   (i_rd_en),
    .i_rd_ra   (i_rd_ra),
    .o_rd_vld  (vld_b),
    .o_rd_data (data_b),
    .o_rd_init (init_b)
  );

  rf_byp #(.W(W), .N(N), .RD_N(RD_N), .WR_N(WR_N), .BYP_EN(0)) u_dut_n (
    .clk       (clk),
    .arst_n    (arst_n),
    .i_clr     (i_clr),
    .i_wr_en   (i_wr_en),
    .i_wr_wa   (i_wr_wa),
    .i_wr_data (i_wr_data),
    .i_rd_en   (i_rd_en),
    .i_rd_ra   (i_rd_ra),
    .o_rd_vld  (vld_n),
    .o_rd_data (data_n),
    .o_rd_init (init_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    i_clr     = 1'b0;
    i_wr_en   = '0;
    i_wr_wa   = '0;
    i_wr_data = '0;
    i_rd_en   = '0;
    i_rd_ra   = '0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] d);
    i_wr_en[p]          = 1'b1;
    i_wr_wa[p*AW +: AW] = a;
    i_wr_data[p*W +: W] = d;
  endtask

  task automatic rd(input int r, input logic [AW-1:0] a);
    i_rd_en[r]          = 1'b1;
    i_rd_ra[r*AW +: AW] = a;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic exp_rd(input string tag, input int r, input logic v,
                        input logic [31:0] db, input logic ib,
                        input logic [31:0] dn, input logic in_);
    check({tag, "/vld_b"},  {31'd0, vld_b[r]},  {31'd0, v});
    check({tag, "/data_b"}, data_b[r*W +: W],   db);
    check({tag, "/init_b"}, {31'd0, init_b[r]}, {31'd0, ib});
    check({tag, "/vld_n"},  {31'd0, vld_n[r]},  {31'd0, v});
    check({tag, "/data_n"}, data_n[r*W +: W],   dn);
    check({tag, "/init_n"}, {31'd0, init_n[r]}, {31'd0, in_});
  endtask

  initial begin
    idle();
    arst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_rd("rst_p0", 0, 0, 0, 0, 0, 0);
    exp_rd("rst_p1", 1, 0, 0, 0, 0, 0);
    arst_n = 1'b1;

    rd(0, 5);
    step(); idle();
    exp_rd("unwr5_p0", 0, 1, 0, 0, 0, 0);
    exp_rd("unwr5_p1", 1, 0, 0, 0, 0, 0);
    step();
    exp_rd("idle_p0", 0, 0, 0, 0, 0, 0);

    wr(0, 3, 32'hDEAD_BEEF);
    step(); idle();
    rd(0, 3); rd(1, 3);
    step(); idle();
    exp_rd("rd3_p0", 0, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1);
    exp_rd("rd3_p1", 1, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1);
    step();
    exp_rd("hold3_p0", 0, 0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1);
    exp_rd("hold3_p1", 1, 0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1);

    wr(0, 7, 32'h11); wr(1, 7, 32'h22);
    step(); idle();
    rd(0, 7);
    step(); idle();
    exp_rd("prio7", 0, 1, 32'h22, 1, 32'h22, 1);

    wr(0, 4, 32'hA);
    step(); idle();
    wr(1, 4, 32'hB); wr(0, 9, 32'h77);
    rd(0, 4); rd(1, 9);
    step(); idle();
    exp_rd("byp4", 0, 1, 32'hB, 1, 32'hA, 1);
    exp_rd("byp9", 1, 1, 32'h77, 1, 32'h0, 0);
    rd(0, 4); rd(1, 9);
    step(); idle();
    exp_rd("after4", 0, 1, 32'hB, 1, 32'hB, 1);
    exp_rd("after9", 1, 1, 32'h77, 1, 32'h77, 1);

    wr(0, 2, 32'h5);
    step(); idle();
    i_clr = 1'b1;
    wr(0, 6, 32'h9);
    rd(0, 2); rd(1, 6);
    step(); idle();
    exp_rd("clr2", 0, 1, 32'h0, 0, 32'h5, 1);
    exp_rd("clr6", 1, 1, 32'h9, 1, 32'h0, 0);
    rd(0, 2); rd(1, 6);
    step(); idle();
    exp_rd("post2", 0, 1, 32'h0, 0, 32'h0, 0);
    exp_rd("post6", 1, 1, 32'h9, 1, 32'h9, 1);
    rd(0, 3); rd(1, 4);
    step(); idle();
    exp_rd("stale3", 0, 1, 32'h0, 0, 32'h0, 0);
    exp_rd("stale4", 1, 1, 32'h0, 0, 32'h0, 0);

    rd(0, 6); rd(1, 7);
    @(posedge clk);
    #1;
    idle();
    exp_rd("pre_rst6", 0, 1, 32'h9, 1, 32'h9, 1);
    exp_rd("pre_rst7", 1, 1, 32'h0, 0, 32'h0, 0);
    #2;
    arst_n = 1'b0;
    #1;
    exp_rd("arst_p0", 0, 0, 0, 0, 0, 0);
    exp_rd("arst_p1", 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    arst_n = 1'b1;
    step();
    exp_rd("norsp_p0", 0, 0, 0, 0, 0, 0);
    exp_rd("norsp_p1", 1, 0, 0, 0, 0, 0);
    rd(0, 6);
    step(); idle();
    exp_rd("rst_inv6", 0, 1, 32'h0, 0, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
